// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: four display patterns (count, rotate, bounce, blink)
// stepped at a switch-selected rate, with a debounced push-button to change mode.
module led_pattern_sequencer #(
  parameter int TICK_DIV        = 1000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [3:0] SW,
  input  logic       BTNC,
  output logic [7:0] LED,
  output logic [1:0] MODE,
  output logic       STEP
);

  localparam int              PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    M_COUNT  = 2'd0,
    M_SHIFT  = 2'd1,
    M_BOUNCE = 2'd2,
    M_BLINK  = 2'd3
  } mode_t;

  // Handshake-free design: adv and step are single-cycle strobes; adv has
  // priority over step whenever both are high in the same cycle.

  logic [3:0]       r_sw_s1, r_sw_s2;
  logic             r_btn_s1, r_btn_s2;
  logic [PRE_W-1:0] r_pre;
  logic [2:0]       r_sub;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_db_level, r_db_prev;
  mode_t            r_mode, w_mode_nxt;
  logic [7:0]       r_led, w_led_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_step;

  logic       w_run, w_dir_sw;
  logic [1:0] w_speed;
  logic       w_base_tick;
  logic [2:0] w_sub_last;
  logic       w_sub_done;
  logic       w_adv;
  logic       w_step;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_sw_s1  <= SW;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= BTNC;
      r_btn_s2 <= r_btn_s1;
    end
  end

  assign w_run    = r_sw_s2[0];
  assign w_dir_sw = r_sw_s2[1];
  assign w_speed  = r_sw_s2[3:2];

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_pre <= '0;
    end else if (r_pre == PRE_LAST) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign w_base_tick = (r_pre == PRE_LAST);

  always_comb begin
    w_sub_last = 3'd0;
    case (w_speed)
      2'd0: w_sub_last = 3'd0;
      2'd1: w_sub_last = 3'd1;
      2'd2: w_sub_last = 3'd3;
      2'd3: w_sub_last = 3'd7;
    endcase
  end

  // >= rather than == so that lowering the speed mid-count steps on the next tick.
  assign w_sub_done = (r_sub >= w_sub_last);
  assign w_step     = w_base_tick & w_run & w_sub_done & ~w_adv;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_sub <= '0;
    end else if (w_adv) begin
      r_sub <= '0;
    end else if (w_base_tick && w_run) begin
      r_sub <= w_sub_done ? 3'd0 : r_sub + 3'd1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
    end else begin
      r_db_prev <= r_db_level;
      if (r_btn_s2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_level <= r_btn_s2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_adv = r_db_level & ~r_db_prev;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_mode <= M_COUNT;
      r_led  <= 8'h00;
      r_dir  <= 1'b0;
      r_step <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_led  <= w_led_nxt;
      r_dir  <= w_dir_nxt;
      r_step <= w_step;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    w_led_nxt  = r_led;
    w_dir_nxt  = r_dir;
    if (w_adv) begin
      case (r_mode)
        M_COUNT:  begin w_mode_nxt = M_SHIFT;  w_led_nxt = 8'h01; end
        M_SHIFT:  begin w_mode_nxt = M_BOUNCE; w_led_nxt = 8'h01; w_dir_nxt = 1'b0; end
        M_BOUNCE: begin w_mode_nxt = M_BLINK;  w_led_nxt = 8'hFF; end
        M_BLINK:  begin w_mode_nxt = M_COUNT;  w_led_nxt = 8'h00; end
      endcase
    end else if (w_step) begin
      case (r_mode)
        M_COUNT:  w_led_nxt = w_dir_sw ? r_led - 8'd1 : r_led + 8'd1;
        M_SHIFT:  w_led_nxt = w_dir_sw ? {r_led[0], r_led[7:1]} : {r_led[6:0], r_led[7]};
        M_BOUNCE: begin
          // Reversal happens on the step that leaves an end, so each end is shown once.
          if (!r_dir) begin
            if (r_led[7]) begin
              w_led_nxt = r_led >> 1;
              w_dir_nxt = 1'b1;
            end else begin
              w_led_nxt = r_led << 1;
            end
          end else begin
            if (r_led[0]) begin
              w_led_nxt = r_led << 1;
              w_dir_nxt = 1'b0;
            end else begin
              w_led_nxt = r_led >> 1;
            end
          end
        end
        M_BLINK:  w_led_nxt = ~r_led;
      endcase
    end
  end

  assign LED  = r_led;
  assign MODE = r_mode;
  assign STEP = r_step;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: table of step/press vectors plus
// hand-written sequences for reset, pause, glitch rejection and adv/step collision.
module tb_led_pattern_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       btnc;
  logic [7:0] led;
  logic [1:0] mode;
  logic       step;

  int n_checks = 0;
  int n_fail   = 0;

  led_pattern_sequencer #(
    .TICK_DIV       (10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .SW        (sw),
    .BTNC      (btnc),
    .LED       (led),
    .MODE      (mode),
    .STEP      (step)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit         press;
    logic [3:0] sw;
    logic [7:0] led;
    logic [1:0] mode;
    int         gap;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit p, input logic [3:0] s, input logic [7:0] l,
                              input logic [1:0] m, input int g);
    vec_t v;
    v.press = p;
    v.sw    = s;
    v.led   = l;
    v.mode  = m;
    v.gap   = g;
    tbl.push_back(v);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_step(input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (step !== 1'b1 && n < max_cyc);
    check("step_seen", 32'(step), 32'd1);
  endtask

  task automatic press_btn(input logic [1:0] exp_mode, input logic [7:0] exp_led, input int hold);
    int         changes;
    logic [1:0] prev;
    changes = 0;
    prev    = mode;
    btnc    = 1'b1;
    for (int i = 0; i < hold + 12; i++) begin
      if (i == hold) btnc = 1'b0;
      tick();
      if (mode !== prev) begin
        changes++;
        if (changes == 1) check("press_led", 32'(led), 32'(exp_led));
        prev = mode;
      end
    end
    check("press_adv_count", 32'(changes), 32'd1);
    check("press_mode", 32'(mode), 32'(exp_mode));
  endtask

  task automatic run_table(input int lo, input int hi);
    int gap;
    for (int i = lo; i < hi; i++) begin
      sw = tbl[i].sw;
      if (tbl[i].press) begin
        press_btn(tbl[i].mode, tbl[i].led, 50);
      end else begin
        wait_step(200, gap);
        check("tbl_led", 32'(led), 32'(tbl[i].led));
        check("tbl_mode", 32'(mode), 32'(tbl[i].mode));
        if (tbl[i].gap != 0) check("tbl_gap", 32'(gap), 32'(tbl[i].gap));
      end
    end
  endtask

  initial begin
    int a_end;
    int gap;
    int steps;

    // COUNT, direction change with wrap, then speed 8
    add(0, 4'b0001, 8'h02, 2'd0, 10);
    add(0, 4'b0011, 8'h01, 2'd0, 10);
    add(0, 4'b0011, 8'h00, 2'd0, 10);
    add(0, 4'b0011, 8'hFF, 2'd0, 10);
    add(0, 4'b1101, 8'h00, 2'd0, 80);
    add(0, 4'b1101, 8'h01, 2'd0, 80);
    a_end = tbl.size();
    // mode cycling by button
    add(1, 4'b0000, 8'h01, 2'd1, 0);
    add(1, 4'b0000, 8'h01, 2'd2, 0);
    add(1, 4'b0000, 8'hFF, 2'd3, 0);
    add(1, 4'b0000, 8'h00, 2'd0, 0);
    add(1, 4'b0000, 8'h01, 2'd1, 0);
    // SHIFT left through the wrap, then right
    add(0, 4'b0001, 8'h02, 2'd1, 0);
    add(0, 4'b0001, 8'h04, 2'd1, 10);
    add(0, 4'b0001, 8'h08, 2'd1, 10);
    add(0, 4'b0001, 8'h10, 2'd1, 10);
    add(0, 4'b0001, 8'h20, 2'd1, 10);
    add(0, 4'b0001, 8'h40, 2'd1, 10);
    add(0, 4'b0001, 8'h80, 2'd1, 10);
    add(0, 4'b0001, 8'h01, 2'd1, 10);
    add(0, 4'b0011, 8'h80, 2'd1, 10);
    add(0, 4'b0011, 8'h40, 2'd1, 10);
    // BOUNCE with SW[1]=1 (ignored)
    add(1, 4'b0000, 8'h01, 2'd2, 0);
    add(0, 4'b0011, 8'h02, 2'd2, 0);
    add(0, 4'b0011, 8'h04, 2'd2, 10);
    add(0, 4'b0011, 8'h08, 2'd2, 10);
    add(0, 4'b0011, 8'h10, 2'd2, 10);
    add(0, 4'b0011, 8'h20, 2'd2, 10);
    add(0, 4'b0011, 8'h40, 2'd2, 10);
    add(0, 4'b0011, 8'h80, 2'd2, 10);
    add(0, 4'b0011, 8'h40, 2'd2, 10);
    add(0, 4'b0011, 8'h20, 2'd2, 10);
    add(0, 4'b0011, 8'h10, 2'd2, 10);
    add(0, 4'b0011, 8'h08, 2'd2, 10);
    add(0, 4'b0011, 8'h04, 2'd2, 10);
    add(0, 4'b0011, 8'h02, 2'd2, 10);
    add(0, 4'b0011, 8'h01, 2'd2, 10);
    add(0, 4'b0011, 8'h02, 2'd2, 10);
    // BLINK, then back to COUNT and up to 05
    add(1, 4'b0000, 8'hFF, 2'd3, 0);
    add(0, 4'b0011, 8'h00, 2'd3, 0);
    add(0, 4'b0011, 8'hFF, 2'd3, 10);
    add(0, 4'b0011, 8'h00, 2'd3, 10);
    add(1, 4'b0000, 8'h00, 2'd0, 0);
    add(0, 4'b0001, 8'h01, 2'd0, 0);
    add(0, 4'b0001, 8'h02, 2'd0, 10);
    add(0, 4'b0001, 8'h03, 2'd0, 10);
    add(0, 4'b0001, 8'h04, 2'd0, 10);
    add(0, 4'b0001, 8'h05, 2'd0, 10);

    sw    = 4'b0001;
    btnc  = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_led", 32'(led), 32'h00);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    rst_n = 1'b1;

    // 100 cycles of COUNT: steps on edges 10..100
    repeat (100) tick();
    check("run100_led", 32'(led), 32'h0A);
    check("run100_step", 32'(step), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'h00);
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_step", 32'(step), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_step(200, gap);
    check("first_step_gap", 32'(gap), 32'd10);
    check("first_step_led", 32'(led), 32'h01);

    run_table(0, a_end);

    // pause: run=0 freezes LED and suppresses STEP
    sw    = 4'b1100;
    steps = 0;
    repeat (200) begin
      tick();
      if (step === 1'b1) steps++;
    end
    check("pause_steps", 32'(steps), 32'd0);
    check("pause_led", 32'(led), 32'h01);
    sw = 4'b1101;
    wait_step(200, gap);
    check("resume_led", 32'(led), 32'h02);

    // a 3-cycle glitch is shorter than the debounce window
    sw   = 4'b0000;
    btnc = 1'b1;
    repeat (3) tick();
    btnc = 1'b0;
    repeat (20) tick();
    check("glitch_mode", 32'(mode), 32'd0);
    check("glitch_led", 32'(led), 32'h02);

    run_table(a_end, tbl.size());

    // adv lands on the same edge as a step at LED=05
    repeat (3) tick();
    btnc = 1'b1;
    repeat (6) tick();
    check("coll_pre_mode", 32'(mode), 32'd0);
    check("coll_pre_led", 32'(led), 32'h05);
    tick();
    check("coll_mode", 32'(mode), 32'd1);
    check("coll_led", 32'(led), 32'h01);
    check("coll_step", 32'(step), 32'd0);
    btnc = 1'b0;
    wait_step(200, gap);
    check("post_coll_gap", 32'(gap), 32'd10);
    check("post_coll_led", 32'(led), 32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
